// File: rtl/picomips_decoder.sv
// PicoMIPS instruction decoder.
// Turns the 6-bit opcode into PC-sequencing, ALU, operand-select,
// write-enable, store and display controls. Decode is combinational.
// The only state is a synchroniser on the asynchronous `ready` switch.
// Branches are taken when the synchronised `ready` equals `branch_cond`.
//
// Ports:
//   clk          system clock, rising edge
//   n_reset      asynchronous active-low reset; forces every output to 0
//   opcode       top OPW bits of the instruction
//   flags        ALU flags {V,N,Z,C}; reserved, no effect on any output
//   ready        branch status switch, asynchronous to clk
//   branch_cond  branch condition switch, quasi-static
//   pc_incr      PC <= PC + 1
//   pc_abs       PC <= immediate
//   pc_rel       PC <= PC + immediate
//   alu_func     ALU operation code
//   imm          selects the immediate as ALU operand B
//   w            register-file write enable
//   store        latch the ALU result into the store/output register
//   disp         drive the display from register A
module picomips_decoder #(
    parameter int unsigned OPW         = 6,
    parameter int unsigned AFW         = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [OPW-1:0] opcode,
    input  logic [3:0]     flags,
    input  logic           ready,
    input  logic           branch_cond,
    output logic           pc_incr,
    output logic           pc_abs,
    output logic           pc_rel,
    output logic [AFW-1:0] alu_func,
    output logic           imm,
    output logic           w,
    output logic           store,
    output logic           disp
);

    // Opcode map
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_MULI = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDS = OPW'(6'b000110);
    localparam logic [OPW-1:0] OP_BABS = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_BREL = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_SHOW = OPW'(6'b001001);

    // ALU function codes
    localparam logic [AFW-1:0] ALU_RA  = AFW'(3'b000);
    localparam logic [AFW-1:0] ALU_ADD = AFW'(3'b001);
    localparam logic [AFW-1:0] ALU_SUB = AFW'(3'b010);
    localparam logic [AFW-1:0] ALU_MUL = AFW'(3'b011);

    // A single flop would leave metastability unresolved.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("picomips_decoder: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ready_s;
    logic                   taken;
    logic                   unused_flags;

    // Flags are reserved for future conditional branches.
    assign unused_flags = ^flags;

    // Synchroniser for the asynchronous ready switch
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ready};
        end
    end

    assign ready_s = sync_q[SYNC_STAGES-1];
    assign taken   = (ready_s == branch_cond);

    // Opcode decode; reset overrides everything so the PC holds.
    always_comb begin
        pc_incr  = 1'b0;
        pc_abs   = 1'b0;
        pc_rel   = 1'b0;
        alu_func = ALU_RA;
        imm      = 1'b0;
        w        = 1'b0;
        store    = 1'b0;
        disp     = 1'b0;
        if (n_reset) begin
            pc_incr = 1'b1;
            unique case (opcode)
                OP_ADD: begin
                    alu_func = ALU_ADD;
                    w        = 1'b1;
                end
                OP_ADDI: begin
                    alu_func = ALU_ADD;
                    imm      = 1'b1;
                    w        = 1'b1;
                end
                OP_SUB: begin
                    alu_func = ALU_SUB;
                    w        = 1'b1;
                end
                OP_SUBI: begin
                    alu_func = ALU_SUB;
                    imm      = 1'b1;
                    w        = 1'b1;
                end
                OP_MUL: begin
                    alu_func = ALU_MUL;
                    w        = 1'b1;
                end
                OP_MULI: begin
                    alu_func = ALU_MUL;
                    imm      = 1'b1;
                    w        = 1'b1;
                end
                OP_ADDS: begin
                    alu_func = ALU_ADD;
                    w        = 1'b1;
                    store    = 1'b1;
                end
                OP_BABS: begin
                    imm     = 1'b1;
                    pc_abs  = taken;
                    pc_incr = !taken;
                end
                OP_BREL: begin
                    imm     = 1'b1;
                    pc_rel  = taken;
                    pc_incr = !taken;
                end
                OP_SHOW: begin
                    disp = 1'b1;
                end
                default: begin
                    // NOP and all unassigned codes: advance only.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picomips_decoder.sv
module tb_picomips_decoder;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [5:0] opcode;
    logic [3:0] flags;
    logic       ready;
    logic       branch_cond;
    logic       pc_incr, pc_abs, pc_rel, imm, w, store, disp;
    logic [2:0] alu_func;

    int total = 0;
    int bad   = 0;

    // Packed view: {pc_incr,pc_abs,pc_rel,alu_func[2:0],imm,w,store,disp}
    localparam logic [9:0] V_ZERO  = 10'b000_000_0000;
    localparam logic [9:0] V_NOP   = 10'b100_000_0000;
    localparam logic [9:0] V_ADD   = 10'b100_001_0100;
    localparam logic [9:0] V_ADDI  = 10'b100_001_1100;
    localparam logic [9:0] V_SUB   = 10'b100_010_0100;
    localparam logic [9:0] V_SUBI  = 10'b100_010_1100;
    localparam logic [9:0] V_MUL   = 10'b100_011_0100;
    localparam logic [9:0] V_MULI  = 10'b100_011_1100;
    localparam logic [9:0] V_ADDS  = 10'b100_001_0110;
    localparam logic [9:0] V_BNT   = 10'b100_000_1000;
    localparam logic [9:0] V_BABS  = 10'b010_000_1000;
    localparam logic [9:0] V_BREL  = 10'b001_000_1000;
    localparam logic [9:0] V_SHOW  = 10'b100_000_0001;

    localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b000001, SUB = 6'b000010,
                           SUBI = 6'b000011, MUL = 6'b000100, MULI = 6'b000101,
                           ADDS = 6'b000110, BABS = 6'b000111, BREL = 6'b001000,
                           SHOW = 6'b001001, NOP = 6'b111111;

    picomips_decoder dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .opcode      (opcode),
        .flags       (flags),
        .ready       (ready),
        .branch_cond (branch_cond),
        .pc_incr     (pc_incr),
        .pc_abs      (pc_abs),
        .pc_rel      (pc_rel),
        .alu_func    (alu_func),
        .imm         (imm),
        .w           (w),
        .store       (store),
        .disp        (disp)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {pc_incr, pc_abs, pc_rel, alu_func, imm, w, store, disp};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops  [12];
    logic [9:0] exps [12];

    initial begin
        n_reset = 1'b0; opcode = NOP; flags = 4'h0; ready = 1'b0; branch_cond = 1'b0;
        #1;
        chk("rst_nop", outs(), V_ZERO);
        opcode = ADD; #1;
        chk("rst_add", outs(), V_ZERO);
        opcode = BREL; #1;
        chk("rst_brel", outs(), V_ZERO);
        tick(); tick();
        n_reset = 1'b1; opcode = NOP; #1;
        chk("nop", outs(), V_NOP);

        // Arithmetic sweep at 10 ns steps
        opcode = ADD;  #1; chk("add",  outs(), V_ADD);  #9;
        opcode = ADDI; #1; chk("addi", outs(), V_ADDI); #9;
        opcode = ADDS; #1; chk("adds", outs(), V_ADDS); #9;
        opcode = SUB;  #1; chk("sub",  outs(), V_SUB);  #9;
        opcode = SUBI; #1; chk("subi", outs(), V_SUBI); #9;
        opcode = MUL;  #1; chk("mul",  outs(), V_MUL);  #9;
        opcode = MULI; #1; chk("muli", outs(), V_MULI); #9;

        // ready_s=1, cond=0: branches not taken
        ready = 1'b1; branch_cond = 1'b0;
        tick(); tick(); tick();
        opcode = BREL; #1; chk("brel_nt", outs(), V_BNT);
        opcode = BABS; #1; chk("babs_nt", outs(), V_BNT);

        // Drop ready: two cycles of latency, then taken
        tick();
        ready = 1'b0; opcode = BREL; #1;
        chk("brel_sync0", outs(), V_BNT);
        tick();
        chk("brel_sync1", outs(), V_BNT);
        tick();
        chk("brel_taken", outs(), V_BREL);
        opcode = BABS; #1;
        chk("babs_taken", outs(), V_BABS);

        opcode = SHOW;      #1; chk("show",    outs(), V_SHOW);
        opcode = 6'b010101; #1; chk("illegal", outs(), V_NOP);

        // Flags have no effect (branches taken: ready_s=0, cond=0)
        ops[0] = ADD;  exps[0] = V_ADD;   ops[1] = ADDI;  exps[1] = V_ADDI;
        ops[2] = SUB;  exps[2] = V_SUB;   ops[3] = SUBI;  exps[3] = V_SUBI;
        ops[4] = MUL;  exps[4] = V_MUL;   ops[5] = MULI;  exps[5] = V_MULI;
        ops[6] = ADDS; exps[6] = V_ADDS;  ops[7] = BABS;  exps[7] = V_BABS;
        ops[8] = BREL; exps[8] = V_BREL;  ops[9] = SHOW;  exps[9] = V_SHOW;
        ops[10] = NOP; exps[10] = V_NOP;  ops[11] = 6'b100000; exps[11] = V_NOP;
        for (int i = 0; i < 12; i++) begin
            opcode = ops[i];
            for (int f = 0; f < 16; f++) begin
                flags = 4'(f); #1;
                chk($sformatf("flags_op%0d_f%0d", i, f), outs(), exps[i]);
            end
        end
        flags = 4'h0;

        // Reset pulse mid-BREL-taken with ready=cond=1
        ready = 1'b1; branch_cond = 1'b1; opcode = BREL;
        tick(); tick(); tick();
        chk("brel_taken_hi", outs(), V_BREL);
        #2; n_reset = 1'b0; #1;
        chk("rst_mid_brel", outs(), V_ZERO);
        tick();
        chk("rst_hold_edge", outs(), V_ZERO);
        n_reset = 1'b1; #1;
        chk("rel_nt0", outs(), V_BNT);
        tick();
        chk("rel_nt1", outs(), V_BNT);
        tick();
        chk("rel_taken", outs(), V_BREL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
